// File: rtl/uart_pkg.sv
// Shared UART click-link definitions: frame FSM states and the default click payload.
// Imported by both the click transmitter and the matching receiver.
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } uart_state_e;

    localparam logic [7:0] CLICK_BYTE_DEFAULT = 8'h43;
    localparam int unsigned BIT_CNT_W = 10;

endpackage

// File: rtl/uart_baud_tick.sv
// Bit-period counter: one-cycle tick at the end of each bit time, cleared on frame load.
module uart_baud_tick
    import uart_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = 564
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic en_i,
    input  logic restart_i,
    output logic tick_o
);

    localparam logic [BIT_CNT_W-1:0] LastCnt = BIT_CNT_W'(CLKS_PER_BIT - 1);

    logic [BIT_CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (restart_i) begin
            cnt_d = '0;
        end else if (en_i) begin
            cnt_d = (cnt_q == LastCnt) ? '0 : cnt_q + 1'b1;
        end
    end

    // Tick depends only on the count, so a STOP-end reload can use it without a loop.
    assign tick_o = en_i && (cnt_q == LastCnt);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/uart_click_tx.sv
// Click-to-UART transmitter: every accepted click sends one 8N1 frame carrying CLICK_BYTE,
// with up to three clicks queued and back-to-back frames when more are pending.
module uart_click_tx
    import uart_pkg::*;
#(
    parameter int unsigned CLK_FREQ   = 65_000_000,
    parameter int unsigned BAUD       = 115_200,
    parameter logic [7:0]  CLICK_BYTE = CLICK_BYTE_DEFAULT
) (
    input  logic clk,
    input  logic rst,
    input  logic click_pulse,
    output logic tx_out,
    output logic busy,
    output logic drop_pulse
);

    localparam int unsigned CLKS_PER_BIT = CLK_FREQ / BAUD;

    if (CLKS_PER_BIT < 2 || CLKS_PER_BIT > 1023) begin : g_bad_clks_per_bit
        $error("uart_click_tx: CLKS_PER_BIT must be within 2..1023");
    end

    uart_state_e state_q, state_d;
    logic [1:0]  pend_q, pend_d;
    logic [2:0]  idx_q, idx_d;
    logic [2:0]  idx_nxt;
    logic        tx_q, tx_d;
    logic        busy_q, busy_d;
    logic        drop_q, drop_d;
    logic        load, accept, tick;

    uart_baud_tick #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_baud_tick (
        .clk_i    (clk),
        .rst_ni   (rst),
        .en_i     (state_q != IDLE),
        .restart_i(load),
        .tick_o   (tick)
    );

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        tx_d    = tx_q;
        load    = 1'b0;
        idx_nxt = idx_q + 3'd1;
        unique case (state_q)
            IDLE:  load = (pend_q != 2'd0);
            START: if (tick) begin
                state_d = DATA;
                idx_d   = 3'd0;
                tx_d    = CLICK_BYTE[0];
            end
            DATA:  if (tick) begin
                if (idx_q == 3'd7) begin
                    state_d = STOP;
                    tx_d    = 1'b1;
                end else begin
                    idx_d = idx_nxt;
                    tx_d  = CLICK_BYTE[idx_nxt];
                end
            end
            STOP:  if (tick) begin
                // Reload straight from STOP so queued frames follow with no idle gap.
                if (pend_q != 2'd0) load = 1'b1;
                else                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        if (load) begin
            state_d = START;
            idx_d   = 3'd0;
            tx_d    = 1'b0;
        end

        accept = click_pulse && ((pend_q != 2'd3) || load);
        drop_d = click_pulse && (pend_q == 2'd3) && !load;
        unique case ({accept, load})
            2'b10:   pend_d = pend_q + 2'd1;
            2'b01:   pend_d = pend_q - 2'd1;
            default: pend_d = pend_q;
        endcase
        busy_d = (state_d != IDLE) || (pend_d != 2'd0);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            pend_q  <= 2'd0;
            idx_q   <= 3'd0;
            tx_q    <= 1'b1;
            busy_q  <= 1'b0;
            drop_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            pend_q  <= pend_d;
            idx_q   <= idx_d;
            tx_q    <= tx_d;
            busy_q  <= busy_d;
            drop_q  <= drop_d;
        end
    end

    assign tx_out     = tx_q;
    assign busy       = busy_q;
    assign drop_pulse = drop_q;

endmodule

// File: tb/tb_uart_click_tx.sv
// Directed bench for uart_click_tx at default parameters; a small line receiver model
// decodes frames from tx_out and the checks compare against hand-computed values.
module tb_uart_click_tx;

    localparam int unsigned CPB   = 564;
    localparam int unsigned HALF  = CPB / 2;
    localparam int unsigned FRAME = 10 * CPB;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic click_pulse = 1'b0;
    logic tx_out, busy, drop_pulse;

    always #5 clk = ~clk;

    uart_click_tx dut (
        .clk        (clk),
        .rst        (rst),
        .click_pulse(click_pulse),
        .tx_out     (tx_out),
        .busy       (busy),
        .drop_pulse (drop_pulse)
    );

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Line model: start detected at first low sample, each bit sampled at its middle.
    logic        m_busy = 1'b0;
    int unsigned m_cnt = 0, m_start = 0;
    logic [7:0]  m_byte = 8'h00, last_byte = 8'h00;
    int unsigned frames = 0, frame_errs = 0, drops = 0;
    int unsigned starts[$];

    always @(negedge clk) begin
        if (rst && drop_pulse) drops <= drops + 1;
        if (!rst) begin
            m_busy <= 1'b0;
        end else if (!m_busy) begin
            if (tx_out == 1'b0) begin
                m_busy  <= 1'b1;
                m_cnt   <= 1;
                m_start <= cyc;
            end
        end else begin
            m_cnt <= m_cnt + 1;
            if (m_cnt % CPB == HALF) begin
                case (m_cnt / CPB)
                    0: if (tx_out !== 1'b0) frame_errs <= frame_errs + 1;
                    9: begin
                        if (tx_out !== 1'b1) frame_errs <= frame_errs + 1;
                        frames    <= frames + 1;
                        last_byte <= m_byte;
                        starts.push_back(m_start);
                        m_busy    <= 1'b0;
                    end
                    default: m_byte <= {tx_out, m_byte[7:1]};
                endcase
            end
        end
    end

    task automatic click();
        @(negedge clk);
        click_pulse = 1'b1;
        @(negedge clk);
        click_pulse = 1'b0;
    endtask

    task automatic wait_idle(input string tag, input int unsigned limit);
        int unsigned n = 0;
        while (busy !== 1'b0 && n < limit) begin
            @(negedge clk);
            n++;
        end
        check_eq({tag, "_idle_in_time"}, 32'(n < limit), 32'd1);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0]  exp_byte;
        int unsigned c0, f0, d0, s0, n, n_low;
        exp_byte = 8'h43;

        repeat (3) @(negedge clk);
        check_eq("rst_tx", 32'(tx_out), 32'd1);
        check_eq("rst_busy", 32'(busy), 32'd0);
        check_eq("rst_drop", 32'(drop_pulse), 32'd0);
        rst = 1'b1;
        repeat (5) @(negedge clk);
        check_eq("idle_tx", 32'(tx_out), 32'd1);
        check_eq("idle_busy", 32'(busy), 32'd0);

        // Single click: latency, bit timing, busy fall after a full frame.
        click();
        check_eq("t1_tx_before_load", 32'(tx_out), 32'd1);
        check_eq("t1_busy_pending", 32'(busy), 32'd1);
        @(negedge clk);
        check_eq("t1_start_low", 32'(tx_out), 32'd0);
        c0 = cyc;
        n = 0;
        while (tx_out === 1'b0 && n < 2000) begin
            @(negedge clk);
            n++;
        end
        check_eq("t1_start_len", n, CPB);
        for (int k = 0; k < 8; k++) begin
            repeat (HALF) @(negedge clk);
            check_eq($sformatf("t1_bit%0d", k), 32'(tx_out), 32'(exp_byte[k]));
            repeat (CPB - HALF) @(negedge clk);
        end
        repeat (HALF) @(negedge clk);
        check_eq("t1_stop_high", 32'(tx_out), 32'd1);
        check_eq("t1_busy_in_stop", 32'(busy), 32'd1);
        wait_idle("t1", 2 * FRAME);
        check_eq("t1_frame_time", cyc - c0, FRAME);
        check_eq("t1_frames", frames, 32'd1);
        check_eq("t1_byte", 32'(last_byte), 32'h43);

        // Two clicks ten cycles apart: back-to-back frames.
        f0 = frames;
        s0 = starts.size();
        click();
        repeat (8) @(negedge clk);
        click();
        wait_idle("t2", 3 * FRAME);
        check_eq("t2_frames", frames - f0, 32'd2);
        if (starts.size() >= s0 + 2) check_eq("t2_gap", starts[s0+1] - starts[s0], FRAME);
        else                         check_eq("t2_gap_frames", starts.size() - s0, 32'd2);

        // Five clicks during one frame: three queue, two drop.
        f0 = frames;
        d0 = drops;
        s0 = starts.size();
        click();
        repeat (500) @(negedge clk);
        repeat (5) begin
            click();
            repeat (200) @(negedge clk);
        end
        check_eq("t3_drops_early", drops - d0, 32'd2);
        wait_idle("t3", 5 * FRAME);
        check_eq("t3_frames", frames - f0, 32'd4);
        check_eq("t3_drops", drops - d0, 32'd2);
        if (starts.size() >= s0 + 4) check_eq("t3_span", starts[s0+3] - starts[s0+1], 2 * FRAME);
        else                         check_eq("t3_span_frames", starts.size() - s0, 32'd4);
        check_eq("t3_byte", 32'(last_byte), 32'h43);

        // Click coinciding with the frame load while one click is pending.
        f0 = frames;
        d0 = drops;
        @(negedge clk);
        click_pulse = 1'b1;
        @(negedge clk);
        @(negedge clk);
        click_pulse = 1'b0;
        check_eq("t4_start_low", 32'(tx_out), 32'd0);
        wait_idle("t4", 3 * FRAME);
        check_eq("t4_frames", frames - f0, 32'd2);
        check_eq("t4_drops", drops - d0, 32'd0);

        // Reset in the middle of a frame, then silence until a new click.
        f0 = frames;
        click();
        @(negedge clk);
        repeat (2000) @(negedge clk);
        check_eq("t5_pre_rst_low", 32'(tx_out), 32'd0);
        rst = 1'b0;
        #1;
        check_eq("t5_rst_tx", 32'(tx_out), 32'd1);
        check_eq("t5_rst_busy", 32'(busy), 32'd0);
        @(negedge clk);
        rst = 1'b1;
        n_low = 0;
        for (int i = 0; i < 7000; i++) begin
            @(negedge clk);
            if (tx_out !== 1'b1) n_low++;
        end
        check_eq("t5_quiet_line", n_low, 32'd0);
        check_eq("t5_quiet_busy", 32'(busy), 32'd0);
        check_eq("t5_no_frame", frames - f0, 32'd0);
        click();
        wait_idle("t5", 2 * FRAME);
        check_eq("t5_frames_after", frames - f0, 32'd1);
        check_eq("t5_byte", 32'(last_byte), 32'h43);
        check_eq("framing_errors", frame_errs, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/uart_click_tx.md
UART_CLICK_TX -- requirements
Module: uart_click_tx

Interface
REQ-001 SHALL have parameter CLK_FREQ, default 65_000_000, system clock frequency in Hz.
REQ-002 SHALL have parameter BAUD, default 115_200, line bit rate.
REQ-003 SHALL have parameter CLICK_BYTE, default 8'h43, payload byte sent per click; uart_click_rx decodes the same value.
REQ-004 SHALL have port clk  input  1  system clock; all state on rising edge.
REQ-005 SHALL have port rst  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port click_pulse  input  1  single-cycle click request, already synchronous to clk.
REQ-007 SHALL have port tx_out  output  1  UART serial line, idle high.
REQ-008 SHALL have port busy  output  1  high while a frame is on the line or a click is pending.
REQ-009 SHALL have port drop_pulse  output  1  one-cycle pulse when a click is discarded.

Function
REQ-010 SHALL use CLKS_PER_BIT = CLK_FREQ/BAUD, integer-truncated; 564 at defaults; each bit lasts exactly CLKS_PER_BIT cycles.
REQ-011 SHALL send each frame as 1 start bit (0), then 8 data bits LSB first, then 1 stop bit (1); a frame lasts 10*CLKS_PER_BIT cycles.
REQ-012 SHALL implement FSM states IDLE, START, DATA, STOP.
- IDLE -> START when pending > 0.
- START -> DATA after one bit time.
- DATA -> STOP after 8 bit times.
- STOP -> IDLE after one bit time.
REQ-013 SHALL keep a pending-click counter, 2 bits, range 0..3.
- Counter +1 on click_pulse.
- Counter -1 when IDLE leaves for START (frame load).
- Simultaneous click and load leaves the counter unchanged.
REQ-014 SHALL discard a click_pulse that arrives with pending = 3 and no load in that cycle, assert drop_pulse in the following cycle, and leave the counter at 3.
REQ-015 SHALL drive tx_out from a register; a click in cycle N, with FSM IDLE and pending 0, drives tx_out low from cycle N+2 (N+1 count, N+2 load and start bit).
REQ-016 SHALL start the next frame with the first cycle after STOP ends when pending > 0, with no extra idle gap.
REQ-017 SHALL ignore clicks for frame content; every frame carries CLICK_BYTE.
REQ-018 SHALL assert busy = (state != IDLE) or (pending != 0), registered.
REQ-019 SHALL keep the bit-period counter at 10 bits with wrap at CLKS_PER_BIT-1; elaboration fails if CLKS_PER_BIT < 2 or > 1023.

Reset
REQ-020 SHALL, on rst low, immediately set tx_out=1, busy=0, drop_pulse=0, state IDLE, pending 0, bit counter 0, bit index 0.
REQ-021 SHALL abort a frame on reset mid-operation; the line returns high with no stop bit; the first frame after release starts only on a new click.

Structure
REQ-022 SHALL place the state enum (IDLE/START/DATA/STOP) and the default CLICK_BYTE in shared package uart_pkg, also imported by uart_click_rx.
REQ-023 SHALL use one sub-module, uart_baud_tick: bit-period counter with enable; it emits a one-cycle tick at the end of each bit time and restarts on frame load.

Verification
REQ-024 Single click, defaults:
- tx_out low for 564 cycles.
- Then bits 1,1,0,0,0,0,1,0 at 564 cycles each.
- Then high for 564 cycles.
- busy falls in the cycle after STOP ends; total frame time 5640 cycles.
REQ-025 Two clicks 10 cycles apart: two back-to-back frames; second start bit begins exactly 5640 cycles after the first; no idle cycle between them.
REQ-026 Five clicks during frame 1:
- pending reaches 3; fourth and fifth clicks each give one drop_pulse.
- Exactly 4 frames total on the line.
REQ-027 Click in the same cycle as a frame load, with pending 1: pending stays 1; two frames total follow.
REQ-028 Reset (rst low) at cycle 2000 of a frame: tx_out high within the same cycle; after release, no frame until a new click.
REQ-029 Loopback tx_out -> uart_click_rx (same parameters), 20 clicks spaced 6000 cycles apart: exactly 20 receiver click_pulse outputs and zero drop_pulse.
